// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: steps each instruction through FETCH/DECODE/
// EXECUTE/MEMORY/WRITEBACK over a shared req/ready memory port and traps on faults.
module multicycle_controller #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [2:0]  mem_size,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_out_we,
  output logic        a_sel,
  output logic        b_sel,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] count, count_n;
  logic [1:0] cause, cause_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       legal;
  logic       expired;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign f7b5        = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign debug_state = state;

  // count holds the number of earlier wait cycles of the current access, so
  // mem_req stays high for exactly MEM_TIMEOUT cycles before the trap.
  assign expired = !mem_ready && (count >= WAIT_LIMIT);

  always_comb begin
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

  // Handshake: mem_req stays asserted until mem_ready is seen high; the access
  // completes in the cycle where both are high, and mem_req is never withdrawn
  // early except by reset or a timeout trap.
  always_comb begin
    state_n      = state;
    count_n      = count;
    cause_n      = cause;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 3'b000;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_out_we   = 1'b0;
    a_sel        = 1'b0;
    b_sel        = 1'b0;
    imm_sel      = IMM_I;
    alu_sel      = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    trap_cause   = cause;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_n = S_DECODE;
          count_n = '0;
        end else if (expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end else begin
          count_n = count + 8'd1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_n = S_TRAP;
          cause_n = CAUSE_SYSTEM;
        end else if (!legal && TRAP_ON_ILLEGAL) begin
          state_n = S_TRAP;
          cause_n = CAUSE_ILLEGAL;
        end else begin
          state_n = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_out_we = 1'b1;
        state_n    = S_WRITEBACK;
        case (opcode)
          OP_R:   alu_sel = {f7b5, funct3};
          OP_IMM: begin
            b_sel   = 1'b1;
            alu_sel = {(funct3 == 3'b101) & f7b5, funct3};
          end
          OP_LOAD: begin
            b_sel   = 1'b1;
            state_n = S_MEMORY;
            count_n = '0;
          end
          OP_STORE: begin
            b_sel   = 1'b1;
            imm_sel = IMM_S;
            state_n = S_MEMORY;
            count_n = '0;
          end
          OP_BRANCH: begin
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_B;
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_ALU : PC_PLUS4;
            state_n = S_FETCH;
            count_n = '0;
          end
          OP_JAL: begin
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_J;
          end
          OP_JALR: b_sel = 1'b1;
          OP_LUI: begin
            b_sel   = 1'b1;
            imm_sel = IMM_U;
            alu_sel = ALU_PASSB;
          end
          OP_AUIPC: begin
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_U;
          end
          default: begin
            // FENCE, or an unknown opcode tolerated as a NOP
            pc_we   = 1'b1;
            state_n = S_FETCH;
            count_n = '0;
          end
        endcase
      end
      S_MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_size     = funct3;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          count_n = '0;
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WRITEBACK;
          end
        end else if (expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end else begin
          count_n = count + 8'd1;
        end
      end
      S_WRITEBACK: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_n = S_FETCH;
        count_n = '0;
        case (opcode)
          OP_LOAD: wb_sel = 2'b01;
          OP_JAL: begin
            wb_sel = 2'b10;
            pc_sel = PC_ALU;
          end
          OP_JALR: begin
            wb_sel = 2'b10;
            pc_sel = PC_JALR;
          end
          default: wb_sel = 2'b00;
        endcase
      end
      S_TRAP:  trap = 1'b1;
      default: state_n = S_FETCH;
    endcase

    // A reset cycle aborts any access and silences every output.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 3'b000;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      alu_out_we   = 1'b0;
      a_sel        = 1'b0;
      b_sel        = 1'b0;
      imm_sel      = 3'b000;
      alu_sel      = 4'b0000;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
      trap         = 1'b0;
      trap_cause   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      count <= '0;
      cause <= 2'b00;
    end else begin
      state <= state_n;
      count <= count_n;
      cause <= cause_n;
    end
  end

endmodule
